// File: rtl/game_board_render.sv
// Pixel renderer for the 4x4 2048 board: latches the board once per frame on the
// vsync falling edge, draws tiles/gaps/background and flashes a border on changed tiles.
module game_board_render #(
  parameter int unsigned FLASH_FRAMES = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [63:0] board,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam logic [7:0]  FLASH_LOAD = 8'(FLASH_FRAMES);
  localparam logic [10:0] X0 = 11'd124;
  localparam logic [10:0] Y0 = 11'd24;
  localparam logic [10:0] BOARD_SZ = 11'd552;

  // Decodes one board-relative axis: {tile hit, tile index, within 4 px of tile edge}.
  function automatic logic [3:0] axis_decode(input logic [10:0] l);
    logic [10:0] off;
    logic        hit;
    logic [1:0]  idx;
    off = 11'd0;
    hit = 1'b1;
    idx = 2'd0;
    if (l >= 11'd8 && l < 11'd136) begin
      idx = 2'd0;
      off = l - 11'd8;
    end else if (l >= 11'd144 && l < 11'd272) begin
      idx = 2'd1;
      off = l - 11'd144;
    end else if (l >= 11'd280 && l < 11'd408) begin
      idx = 2'd2;
      off = l - 11'd280;
    end else if (l >= 11'd416 && l < 11'd544) begin
      idx = 2'd3;
      off = l - 11'd416;
    end else begin
      hit = 1'b0;
    end
    return {hit, idx, (off < 11'd4) || (off >= 11'd124)};
  endfunction

  function automatic logic [11:0] palette(input logic [3:0] e);
    logic [11:0] c;
    case (e)
      4'd0:    c = 12'hCCB;
      4'd1:    c = 12'hEED;
      4'd2:    c = 12'hEEC;
      4'd3:    c = 12'hFB7;
      4'd4:    c = 12'hF96;
      4'd5:    c = 12'hF75;
      4'd6:    c = 12'hF53;
      4'd7:    c = 12'hEC7;
      4'd8:    c = 12'hEC6;
      4'd9:    c = 12'hEC5;
      4'd10:   c = 12'hEC3;
      4'd11:   c = 12'hEC2;
      default: c = 12'h333;
    endcase
    return c;
  endfunction

  logic        vs_prev_q;
  logic        tick_s;
  logic [63:0] board_q, board_d;
  logic [15:0] fmask_q, fmask_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [15:0] chg_s;

  // Gated by rst so the pulse stays low while reset is held.
  assign tick_s     = rst && vs_prev_q && !vsync_in;
  assign frame_tick = tick_s;

  // Per-tile change detection against the currently displayed board.
  always_comb begin
    chg_s = 16'd0;
    for (int t = 0; t < 16; t++) begin
      chg_s[t] = (board[4*t +: 4] != board_q[4*t +: 4]);
    end
  end

  // Frame latch and flash control; a reload takes priority over the countdown.
  always_comb begin
    board_d = board_q;
    fmask_d = fmask_q;
    fcnt_d  = fcnt_q;
    if (tick_s) begin
      board_d = board;
      if (chg_s != 16'd0) begin
        fmask_d = chg_s;
        fcnt_d  = FLASH_LOAD;
      end else if (fcnt_q != 8'd0) begin
        fcnt_d = fcnt_q - 8'd1;
        if (fcnt_q == 8'd1) begin
          fmask_d = 16'd0;
        end else begin
          fmask_d = fmask_q;
        end
      end else begin
        fcnt_d = fcnt_q;
      end
    end else begin
      board_d = board_q;
    end
  end

  // Frame-state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_prev_q <= 1'b1;
      board_q   <= 64'd0;
      fmask_q   <= 16'd0;
      fcnt_q    <= 8'd0;
    end else begin
      vs_prev_q <= vsync_in;
      board_q   <= board_d;
      fmask_q   <= fmask_d;
      fcnt_q    <= fcnt_d;
    end
  end

  logic [10:0] lx_s, ly_s;
  logic [3:0]  dx_s, dy_s;
  logic        vis_s, insq_s;

  assign lx_s   = pixel_x - X0;
  assign ly_s   = {1'b0, pixel_y} - Y0;
  assign vis_s  = valid && (pixel_x < 11'd800) && (pixel_y < 10'd600);
  assign insq_s = (pixel_x >= X0) && (pixel_x < X0 + BOARD_SZ) &&
                  ({1'b0, pixel_y} >= Y0) && ({1'b0, pixel_y} < Y0 + BOARD_SZ);
  assign dx_s   = axis_decode(lx_s);
  assign dy_s   = axis_decode(ly_s);

  logic       s1_vis_q, s1_insq_q, s1_tile_q, s1_edge_q, s1_hs_q, s1_vs_q;
  logic [3:0] s1_idx_q;

  // S1: registered geometry classification.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vis_q  <= 1'b0;
      s1_insq_q <= 1'b0;
      s1_tile_q <= 1'b0;
      s1_edge_q <= 1'b0;
      s1_idx_q  <= 4'd0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
    end else begin
      s1_vis_q  <= vis_s;
      s1_insq_q <= insq_s;
      s1_tile_q <= dx_s[3] && dy_s[3];
      s1_edge_q <= dx_s[0] || dy_s[0];
      s1_idx_q  <= {dy_s[2:1], dx_s[2:1]};
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
    end
  end

  logic [3:0]  exp_s;
  logic [11:0] color_s;

  assign exp_s = board_q[{s1_idx_q, 2'b00} +: 4];

  // S2 colour select in priority order.
  always_comb begin
    color_s = 12'h000;
    if (!s1_vis_q) begin
      color_s = 12'h000;
    end else if (!s1_insq_q) begin
      color_s = 12'hFFE;
    end else if (!s1_tile_q) begin
      color_s = 12'hBA9;
    end else if (fmask_q[s1_idx_q] && s1_edge_q) begin
      color_s = 12'hFFF;
    end else begin
      color_s = palette(exp_s);
    end
  end

  logic [11:0] s2_rgb_q, rgb_q;
  logic        s2_hs_q, s2_vs_q, hs_q, vs_q;

  // S2 and S3 registers; S3 drives the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_rgb_q <= 12'h000;
      s2_hs_q  <= 1'b1;
      s2_vs_q  <= 1'b1;
      rgb_q    <= 12'h000;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      s2_rgb_q <= color_s;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      rgb_q    <= s2_rgb_q;
      hs_q     <= s2_hs_q;
      vs_q     <= s2_vs_q;
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hs_q;
  assign vsync = vs_q;

endmodule

// File: tb/tb_game_board_render.sv
// Self-checking bench for game_board_render against an arithmetic board model.
module tb_game_board_render;
  localparam int FF = 2;
  localparam logic [11:0] PAL [16] = '{12'hCCB, 12'hEED, 12'hEEC, 12'hFB7, 12'hF96, 12'hF75,
                                       12'hF53, 12'hEC7, 12'hEC6, 12'hEC5, 12'hEC3, 12'hEC2,
                                       12'h333, 12'h333, 12'h333, 12'h333};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] pixel_x = 11'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        valid = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [63:0] board = 64'd0;
  logic [11:0] rgb;
  logic        hsync, vsync, frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_bq [16];
  logic [15:0] m_mask = 16'd0;
  int          m_cnt = 0;

  game_board_render #(.FLASH_FRAMES(FF)) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .board(board),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  always #10 clk = ~clk;

  function automatic logic [11:0] model_rgb(int x, int y, bit v);
    int lx, ly, r, c, ox, oy;
    bit edge_px;
    if (!v || x >= 800 || y >= 600) return 12'h000;
    lx = x - 124;
    ly = y - 24;
    if (lx < 0 || lx >= 552 || ly < 0 || ly >= 552) return 12'hFFE;
    if ((lx % 136) < 8 || (ly % 136) < 8) return 12'hBA9;
    c  = lx / 136;
    r  = ly / 136;
    ox = lx % 136 - 8;
    oy = ly % 136 - 8;
    edge_px = (ox < 4) || (ox >= 124) || (oy < 4) || (oy >= 124);
    if (m_mask[4*r+c] && edge_px) return 12'hFFF;
    return PAL[m_bq[4*r+c]];
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 16; t++) m_bq[t] = 0;
    m_mask = 16'd0;
    m_cnt  = 0;
  endtask

  task automatic model_tick();
    logic [15:0] chg;
    chg = 16'd0;
    for (int t = 0; t < 16; t++) chg[t] = (int'(board[4*t +: 4]) != m_bq[t]);
    if (chg != 16'd0) begin
      m_mask = chg;
      m_cnt  = FF;
    end else if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_mask = 16'd0;
    end
    for (int t = 0; t < 16; t++) m_bq[t] = int'(board[4*t +: 4]);
  endtask

  task automatic set_tile(int r, int c, int e);
    board[4*(4*r+c) +: 4] = 4'(e);
  endtask

  task automatic step_frame();
    @(negedge clk);
    valid = 1'b0;
    vsync_in = 1'b1;
    @(negedge clk);
    vsync_in = 1'b0;
    #1;
    n_tests++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_tick_high: got %b expected 1", frame_tick);
    end
    model_tick();
    @(negedge clk);
    #1;
    n_tests++;
    if (frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_tick_pulse: got %b expected 0", frame_tick);
    end
    vsync_in = 1'b1;
  endtask

  task automatic check_pix(int x, int y, bit v, string name);
    logic [11:0] exp_c;
    @(negedge clk);
    pixel_x = 11'(x);
    pixel_y = 10'(y);
    valid   = v;
    exp_c   = model_rgb(x, y, v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rgb !== exp_c) begin
      n_fail++;
      $display("FAIL %s: rgb=%h expected %h (x=%0d y=%0d v=%0d)", name, rgb, exp_c, x, y, v);
    end
  endtask

  task automatic test_reset();
    logic hh [16];
    logic vh [16];
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      valid    = 1'($urandom_range(0, 1));
      pixel_x  = 11'($urandom_range(0, 799));
      pixel_y  = 10'($urandom_range(0, 599));
      board    = {$urandom, $urandom};
      #1;
      n_tests++;
      if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: rgb=%h hs=%b vs=%b tick=%b expected 000 1 1 0",
                 rgb, hsync, vsync, frame_tick);
      end
    end
    @(negedge clk);
    board = 64'd0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        n_tests++;
        if (hsync !== hh[i-3] || vsync !== vh[i-3]) begin
          n_fail++;
          $display("FAIL sync_delay[%0d]: hs=%b vs=%b expected %b %b", i, hsync, vsync, hh[i-3], vh[i-3]);
        end
      end
      hh[i] = 1'($urandom_range(0, 1));
      vh[i] = 1'($urandom_range(0, 1));
      hsync_in = hh[i];
      vsync_in = vh[i];
    end
    @(negedge clk);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
  endtask

  task automatic test_empty();
    board = 64'd0;
    step_frame();
    check_pix(132, 32, 1'b1, "empty_tile");
    check_pix(128, 32, 1'b1, "gap");
    check_pix(50, 300, 1'b1, "background");
    check_pix(132, 32, 1'b0, "not_valid");
    check_pix(800, 100, 1'b1, "x_beyond");
    check_pix(300, 600, 1'b1, "y_beyond");
    check_pix(675, 575, 1'b1, "board_corner_gap");
    check_pix(676, 300, 1'b1, "board_right_edge");
  endtask

  task automatic test_tile_addr();
    board = 64'd0;
    set_tile(1, 2, 11);
    step_frame();
    check_pix(424, 188, 1'b1, "tile_r1c2");
    check_pix(560, 188, 1'b1, "tile_r1c3");
    check_pix(404, 168, 1'b1, "tile_r1c2_border");
  endtask

  task automatic test_flash();
    set_tile(0, 0, 1);
    for (int f = 1; f <= 3; f++) begin
      step_frame();
      check_pix(132, 32, 1'b1, "flash_border");
      check_pix(140, 40, 1'b1, "flash_inner");
      check_pix(259, 159, 1'b1, "flash_far_corner");
    end
    check_pix(404, 168, 1'b1, "flash_other_done");
  endtask

  task automatic test_retrigger();
    set_tile(0, 0, 2);
    step_frame();
    check_pix(132, 32, 1'b1, "retrig_start");
    set_tile(3, 3, 5);
    step_frame();
    check_pix(132, 32, 1'b1, "retrig_old_off");
    check_pix(540, 440, 1'b1, "retrig_new_on");
    step_frame();
    check_pix(540, 440, 1'b1, "retrig_reloaded");
    step_frame();
    check_pix(540, 440, 1'b1, "retrig_expired");
  endtask

  task automatic test_latch_isolation();
    for (int k = 0; k < 3; k++) begin
      board = {$urandom, $urandom};
      check_pix(140, 40, 1'b1, "iso_r0c0");
      check_pix(560, 188, 1'b1, "iso_r1c3");
    end
    step_frame();
    check_pix(140, 40, 1'b1, "iso_new_r0c0");
    check_pix(560, 188, 1'b1, "iso_new_r1c3");
  endtask

  task automatic rand_pixel(output int x, output int y, output bit v);
    x = ($urandom_range(0, 19) == 0) ? 2047 : int'($urandom_range(0, 850));
    y = int'($urandom_range(0, 620));
    v = ($urandom_range(0, 7) != 0);
  endtask

  task automatic test_random();
    int x, y;
    bit v;
    for (int k = 0; k < 6; k++) begin
      if (k % 3 != 2) board = {$urandom, $urandom};
      step_frame();
      for (int p = 0; p < 12; p++) begin
        rand_pixel(x, y, v);
        check_pix(x, y, v, "random_pixel");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q [40];
    int x, y;
    bit v;
    board = {$urandom, $urandom};
    step_frame();
    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        n_tests++;
        if (rgb !== exp_q[i-3]) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: rgb=%h expected %h", i - 3, rgb, exp_q[i-3]);
        end
      end
      if (i < 40) begin
        rand_pixel(x, y, v);
        pixel_x  = 11'(x);
        pixel_y  = 10'(y);
        valid    = v;
        exp_q[i] = model_rgb(x, y, v);
      end
    end
  endtask

  task automatic test_async_reset();
    check_pix(140, 40, 1'b1, "pre_reset_pixel");
    hsync_in = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_tests++;
    if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rgb=%h hs=%b vs=%b tick=%b expected 000 1 1 0",
               rgb, hsync, vsync, frame_tick);
    end
    @(negedge clk);
    rst = 1'b1;
    hsync_in = 1'b1;
    model_reset();
    check_pix(132, 32, 1'b1, "post_reset_board_cleared");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_empty();
    test_tile_addr();
    test_flash();
    test_retrigger();
    test_latch_isolation();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/game_board_render.md
# game_board_render

Pixel-rendering stage placed directly downstream of the 800x600@72Hz VGA timing generator. It consumes the generator's pixel coordinates, valid flag and sync outputs, and draws the 4x4 board of 2048 tiles from a board-state bus. The bus is latched once per frame so the image never tears. Output is registered 12-bit RGB, with syncs delayed to match the pixel pipeline. Changed tiles flash a white border for a programmable number of frames.

## Interface
- FLASH_FRAMES, 36: frames a changed tile keeps its highlight border (half a second at 72 Hz); legal range 1..255.
- clk  in  1  pixel clock, 50 MHz, same clock as the timing generator.
- rst  in  1  asynchronous, active-low reset.
- pixel_x  in  11  horizontal pixel coordinate from the timing generator.
- pixel_y  in  10  vertical pixel coordinate from the timing generator.
- valid  in  1  active-video flag from the timing generator.
- hsync_in  in  1  hsync from the timing generator (active low).
- vsync_in  in  1  vsync from the timing generator (active low).
- board  in  64  tile exponents; board[4*(4*r+c) +: 4] is row r, column c (r,c = 0..3); 0 = empty, n = tile value 2^n.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}, registered.
- hsync  out  1  hsync_in delayed 3 clocks.
- vsync  out  1  vsync_in delayed 3 clocks.
- frame_tick  out  1  one-clock pulse on the cycle board is latched.

## Operation
- Frame latch: a vsync_in falling edge (registered prev=1, now=0) raises frame_tick. On that clock the block does all of the following:
  - board_q <= board.
  - chg <= per-tile (board nibble != board_q nibble).
- Flash control, evaluated on every frame_tick:
  - If any chg bit is set: fmask <= chg, fcnt <= FLASH_FRAMES. A new change replaces the old mask; masks are not ORed.
  - Else if fcnt != 0: fcnt <= fcnt-1, and fmask <= 0 when fcnt reaches 0.
- Geometry is unsigned, 11-bit x / 10-bit y. Use comparators only, no dividers.
  - Board origin X0=124, Y0=24. Board size 552x552 = 4 tiles of 128 plus 5 gaps of 8.
  - lx = x-X0, ly = y-Y0. Tile column c covers lx in [8+136c, 136+136c). Rows use ly the same way.
- Pixel classes, in priority order:
  - valid=0, pixel_x>=800 or pixel_y>=600: 0x000.
  - Outside the board square: 0xFFE.
  - Inside the square but in a gap: 0xBA9.
  - Inside tile (r,c) with fmask[4r+c]=1 and within 4 px of the tile edge: 0xFFF.
  - Otherwise palette[board_q exponent of tile (r,c)].
- Palette by exponent:
  - 0: 0xCCB
  - 1: 0xEED
  - 2: 0xEEC
  - 3: 0xFB7
  - 4: 0xF96
  - 5: 0xF75
  - 6: 0xF53
  - 7: 0xEC7
  - 8: 0xEC6
  - 9: 0xEC5
  - 10: 0xEC3
  - 11: 0xEC2
  - 12..15: 0x333
- Reset values (rst=0), immediately: rgb=0, hsync=1, vsync=1, frame_tick=0, board_q=0, fmask=0, fcnt=0, and all pipeline registers cleared with their sync bits at 1. The prev-vsync register resets to 1, so the first frame latch needs a real falling edge after reset.

## Timing
- Pipeline of 3 stages. Inputs at cycle N produce rgb/hsync/vsync at cycle N+3.
  - S1: register inputs, form in-board, row/col and edge flags.
  - S2: select exponent, then palette/border.
  - S3: output register.
- board_q, fmask and fcnt change only on the frame_tick clock. Pixels in S1 on that clock already use the new values. frame_tick occurs during vertical blanking, so no visible pixel sees a mixed state.
- The board input may change on any clock. Only its value on the frame_tick cycle matters.
- rst asserted mid-frame: outputs go to their reset values asynchronously. After release, the first rgb is valid 3 clocks after the first registered input.
- Simultaneous change while a flash is running: the reload wins over the decrement.

## Test plan
- Reset: hold rst=0 with random inputs -> rgb=0x000, hsync=vsync=1, frame_tick=0. Release -> hsync/vsync track the inputs 3 clocks late.
- Board 0x0 then empty layout: after frame_tick, pixel (132,32) -> 0xCCB; (128,32) -> 0xBA9; (50,300) -> 0xFFE; valid=0 -> 0x000. Each appears 3 clocks after its input.
- Tile addressing: board nibble for r=1,c=2 = 11, others 0; after frame_tick, pixel (404+20,168+20) -> 0xEC2; pixel (540+20,168+20) (c=3) -> 0xCCB.
- Flash: FLASH_FRAMES=2; change r0c0 to 1 -> pixel (132,32) = 0xFFF and (140,40) = 0xEED for frames 1-2; frame 3 -> (132,32) = 0xEED, fmask=0.
- Re-trigger: during a flash change r3c3 only -> the old tile's border vanishes, the r3c3 border is lit and fcnt reloads to FLASH_FRAMES.
- Latch isolation: toggle board mid-frame without a vsync edge -> rgb unchanged until the next frame_tick.
